pig_v5: RTL
===========

# pig_v5

Fifth-generation proportional-integral-gain (PIG) servo controller for the laser/fibre-noise lock loops. It sits between the phase-detector AXI-Stream output and the actuator stream (DDS frequency word or DAC). Relative to the previous generation it adds:
- parametrised accumulator width;
- saturating arithmetic at every stage, with conditional-integration anti-windup;
- hold and clear controls;
- gains captured per sample;
- a true valid-qualified 4-stage pipeline.

## Interface
Parameters:
- AXIS_TDATA_WIDTH, 32, width of input and output stream words
- INPUT_WIDTH, 14, process-variable bits taken from the top of s_axis_pv_tdata
- ACC_WIDTH, 40, internal error/integrator/sum width; must be ≥ INPUT_WIDTH+8
- OUTPUT_WIDTH, 32, internal action width before mapping to AXIS_TDATA_WIDTH

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-low reset
- kp  in  8  signed proportional shift (≥0 left, <0 right)
- ki  in  8  signed integral shift
- kg  in  8  signed overall gain shift
- kg_sign  in  1  1 = negate action
- hold  in  1  1 = freeze integrator; pipeline keeps running
- integrator_clear  in  1  1 = zero integrator
- s_axis_pv_tdata  in  AXIS_TDATA_WIDTH  signed process variable
- s_axis_pv_tvalid  in  1  sample valid; no tready, every valid beat is accepted
- m_axis_action_tdata  out  AXIS_TDATA_WIDTH  signed action
- m_axis_action_tvalid  out  1  one-cycle pulse per result
- sat_flag  out  1  last emitted action was clipped

## Operation
- S1, on accepted beat:
  - pv = tdata[AXIS_TDATA_WIDTH-1 -: INPUT_WIDTH], sign-extended to ACC_WIDTH.
  - error = −pv. No overflow is possible, given the ACC_WIDTH constraint.
  - kp/ki/kg/kg_sign are captured and travel with the sample.
- S2, integrator update (only when the S2 stage is valid):
  - integrator_clear=1 → integrator = 0. This takes priority over everything.
  - Otherwise, hold=1 → integrator unchanged.
  - Otherwise, anti-windup freeze → integrator unchanged. Freeze condition: sat_flag=1 AND the sign of (error XOR kg_sign) matches the direction of the last clip.
  - Otherwise, integrator = sat_ACC(integrator + error).
- S3: sum = sat_ACC(shift(error, kp) + shift(integrator_new, ki)).
  - integrator_new is the S2 result for this sample.
  - shift(x, k): k ≥ 0 → saturating left shift; k < 0 → arithmetic right shift by −k.
  - Shift magnitude is clamped to ACC_WIDTH−1.
- S4: a = shift(sum, kg); if kg_sign=1, a = −a, with −min saturating to max.
  - action = sat_OUT(a), clipped to ±(2^(OUTPUT_WIDTH−1)), with max = 2^(OUTPUT_WIDTH−1)−1.
  - sat_flag records whether the clip was active and its direction (internal direction bit).
- Output mapping:
  - AXIS wider than OUTPUT_WIDTH → action <<< (AXIS−OUTPUT).
  - AXIS narrower → action >>> (OUTPUT−AXIS).
  - Equal widths → pass-through.
- sat_ACC clips to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
- Nothing wraps anywhere.
- m_axis_action_tdata and sat_flag hold their values between valid pulses.

## Timing
- Latency: an accepted beat at edge N produces m_axis_action_tvalid=1 for exactly the cycle after edge N+4.
- Throughput: one sample per cycle. Back-to-back beats give back-to-back pulses.
- Gaps in tvalid propagate as gaps. Stages hold data but only valid stages update state.
- Back-to-back samples: the integrator update of sample k+1 uses the integrator already updated by sample k.
- Anti-windup uses sat_flag as registered at the time S2 executes.
- hold and integrator_clear are sampled on the cycle the sample is in S2.
- Reset (rst=0 at an edge): all stage valids, integrator, action, m_axis_action_tdata, m_axis_action_tvalid and sat_flag go to 0.
- Reset mid-pipeline: samples in flight are discarded; no pulse emerges for them.
- Simultaneous integrator_clear and hold: clear wins.

## Test plan
All cases use defaults unless stated otherwise.
- Basic: kp=ki=kg=0, kg_sign=0, single beat tdata=0x0010_0000 (pv=4) → after 4 cycles, tvalid pulse, tdata=0xFFFF_FFF8 (−8), sat_flag=0.
- Accumulate / hold:
  - Three consecutive beats of pv=4 → outputs −8, −12, −16.
  - Repeat after integrator_clear with hold=1 from the 2nd beat → −8, −8, −8.
- Sign and negative shifts:
  - kg_sign=1, pv=4 → +8 (0x0000_0008).
  - kp=−1, ki=−2, kg_sign=0, pv=−16 → 8+4 = 12 (0x0000_000C).
- Saturation and anti-windup:
  - kp=30, tdata=0x8000_0000 (pv=−8192), 5 beats → every output is 0x7FFF_FFFF with sat_flag=1.
  - Integrator stays 8192 after the first beat.
  - Then pv=+4 → integrator decreases to 8188.
- Reset mid-flight: valid beat, then rst=0 for one cycle two cycles later → no tvalid pulse appears, tdata=0, sat_flag=0, and the next pv=4 beat yields −8.
- Gaps: beats with tvalid pattern 1,0,0,1 (pv=4) → pulses at the matching spacing with values −8, −12.

Source files
------------

// File: rtl/pig_v5_if.sv
// pig_v5_if - stream bundle for the pig_v5 servo controller.
//
// Carries the process-variable input stream and the action output stream.
// Neither stream has tready: every valid input beat is accepted, and the
// action stream is a one-cycle valid pulse per result.
//
// Signals:
//   s_axis_pv_tdata       process-variable word (signed, sample in the top bits)
//   s_axis_pv_tvalid      process-variable beat valid
//   m_axis_action_tdata   actuator word (signed)
//   m_axis_action_tvalid  one-cycle pulse per emitted action
//
// Modports:
//   slave  - the controller (consumes pv, produces action)
//   master - the environment (produces pv, consumes action)
interface pig_v5_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic [AXIS_TDATA_WIDTH-1:0] s_axis_pv_tdata;
    logic                        s_axis_pv_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] m_axis_action_tdata;
    logic                        m_axis_action_tvalid;

    modport slave (
        input  s_axis_pv_tdata,
        input  s_axis_pv_tvalid,
        output m_axis_action_tdata,
        output m_axis_action_tvalid
    );

    modport master (
        output s_axis_pv_tdata,
        output s_axis_pv_tvalid,
        input  m_axis_action_tdata,
        input  m_axis_action_tvalid
    );
endinterface

// File: rtl/pig_v5.sv
// pig_v5 - proportional-integral-gain servo controller, 4-stage pipeline.
//
// Takes a signed process variable from the top INPUT_WIDTH bits of each
// accepted stream beat, forms error = -pv, runs it through a saturating
// integrator with hold/clear/anti-windup, combines P and I terms through
// power-of-two shifts, applies an overall shift gain and optional negation,
// clips to OUTPUT_WIDTH and emits the result on the action stream.
// Every stage saturates; nothing wraps.
//
// Ports:
//   clk               sole clock
//   rst               synchronous, active-low reset
//   kp, ki, kg        signed shift gains (>=0 left shift, <0 arithmetic right)
//   kg_sign           1 = negate the action
//   hold              1 = freeze integrator (pipeline keeps running)
//   integrator_clear  1 = zero integrator (wins over hold)
//   axis              stream bundle (pv in, action out), slave modport
//   sat_flag          last emitted action was clipped
//
// Timing: a beat accepted at edge N gives an action pulse in the cycle after
// edge N+4. Gains travel with their sample; hold/clear are sampled at the
// edge where that sample's integrator update happens (edge N+1).
module pig_v5 #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int INPUT_WIDTH      = 14,
    parameter int ACC_WIDTH        = 40,
    parameter int OUTPUT_WIDTH     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] kp,
    input  logic signed [7:0] ki,
    input  logic signed [7:0] kg,
    input  logic              kg_sign,
    input  logic              hold,
    input  logic              integrator_clear,
    pig_v5_if.slave           axis,
    output logic              sat_flag
);

    // Width used to compare an ACC-wide value against the output range
    // without truncating either side.
    localparam int WIDE = (ACC_WIDTH > OUTPUT_WIDTH) ? ACC_WIDTH : OUTPUT_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [8:0]                  SHIFT_MAX = 9'(ACC_WIDTH-1);

    localparam logic signed [WIDE-1:0] OUT_MAX_W =
        {{(WIDE-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE-1:0] OUT_MIN_W =
        {{(WIDE-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // Clip a one-bit-wider sum back into the accumulator range. The two top
    // bits disagree exactly when the ACC-wide result would have overflowed.
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
        input logic signed [ACC_WIDTH:0] v
    );
        logic signed [ACC_WIDTH-1:0] r;
        if (v[ACC_WIDTH] != v[ACC_WIDTH-1]) begin
            r = v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            r = v[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    // Saturating sum of two accumulator-width values.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        return sat_acc({a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b});
    endfunction

    // Power-of-two gain. k >= 0 shifts left with saturation, k < 0 shifts
    // right arithmetically. The magnitude is clamped to ACC_WIDTH-1 so huge
    // gains degrade to full saturation (left) or sign fill (right).
    function automatic logic signed [ACC_WIDTH-1:0] shift_sat(
        input logic signed [ACC_WIDTH-1:0] x,
        input logic signed [7:0]           k
    );
        logic [8:0]                  mag;
        logic [8:0]                  amt;
        logic signed [ACC_WIDTH-1:0] shl;
        logic signed [ACC_WIDTH-1:0] r;
        // Nine bits so that -(-128) is representable.
        if (k[7]) begin
            mag = 9'd0 - {k[7], k};
        end else begin
            mag = {1'b0, k};
        end
        if (mag > SHIFT_MAX) begin
            amt = SHIFT_MAX;
        end else begin
            amt = mag;
        end
        if (k[7]) begin
            r = x >>> amt;
        end else begin
            shl = x <<< amt;
            // Any bit lost off the top shows up as a mismatch on the way back.
            if ((shl >>> amt) != x) begin
                r = x[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
            end else begin
                r = shl;
            end
        end
        return r;
    endfunction

    // Negation that maps the most negative value to the most positive.
    function automatic logic signed [ACC_WIDTH-1:0] neg_sat(
        input logic signed [ACC_WIDTH-1:0] x
    );
        logic signed [ACC_WIDTH-1:0] r;
        if (x == ACC_MIN) begin
            r = ACC_MAX;
        end else begin
            r = -x;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                          s1_valid_r;
    logic signed [ACC_WIDTH-1:0]   s1_err_r;
    logic signed [7:0]             s1_kp_r;
    logic signed [7:0]             s1_ki_r;
    logic signed [7:0]             s1_kg_r;
    logic                          s1_kg_sign_r;

    logic                          s2_valid_r;
    logic signed [ACC_WIDTH-1:0]   s2_err_r;
    logic signed [7:0]             s2_kp_r;
    logic signed [7:0]             s2_ki_r;
    logic signed [7:0]             s2_kg_r;
    logic                          s2_kg_sign_r;

    logic signed [ACC_WIDTH-1:0]   integrator_r;

    logic                          s3_valid_r;
    logic signed [ACC_WIDTH-1:0]   s3_sum_r;
    logic signed [7:0]             s3_kg_r;
    logic                          s3_kg_sign_r;

    logic                          s4_valid_r;
    logic signed [OUTPUT_WIDTH-1:0] s4_action_r;
    logic                          s4_clip_r;
    logic                          s4_dir_r;

    logic [AXIS_TDATA_WIDTH-1:0]   tdata_r;
    logic                          tvalid_r;
    logic                          sat_flag_r;
    // Direction of the last clip: 0 = clipped high, 1 = clipped low.
    logic                          sat_dir_r;

    // ------------------------------------------------------------------
    // Combinational stage logic
    // ------------------------------------------------------------------
    logic signed [INPUT_WIDTH-1:0]  pv_s;
    logic signed [ACC_WIDTH-1:0]    err_s;
    logic                           freeze_s;
    logic signed [ACC_WIDTH-1:0]    int_next_s;
    logic signed [ACC_WIDTH-1:0]    sum_next_s;
    logic signed [ACC_WIDTH-1:0]    gained_s;
    logic signed [WIDE-1:0]         gained_w_s;
    logic signed [OUTPUT_WIDTH-1:0] action_next_s;
    logic                           clip_next_s;
    logic                           dir_next_s;
    logic [AXIS_TDATA_WIDTH-1:0]    mapped_s;
    logic                           tdata_unused_s;

    // The low bits of the pv word below the sample field carry no information.
    assign tdata_unused_s = ^axis.s_axis_pv_tdata;

    // S1 input: take the sample from the top of the word and negate it. The
    // accumulator headroom guarantees -pv always fits.
    always_comb begin
        pv_s  = axis.s_axis_pv_tdata[AXIS_TDATA_WIDTH-1 -: INPUT_WIDTH];
        err_s = -(ACC_WIDTH'(pv_s));
    end

    // S2 integrator next value: clear beats hold, hold beats anti-windup,
    // otherwise accumulate. Anti-windup stops integrating while the last
    // action was clipped and this error would push further the same way.
    always_comb begin
        int_next_s = integrator_r;
        freeze_s   = sat_flag_r && ((s1_err_r[ACC_WIDTH-1] ^ s1_kg_sign_r) == sat_dir_r);
        if (integrator_clear) begin
            int_next_s = {ACC_WIDTH{1'b0}};
        end else if (hold) begin
            int_next_s = integrator_r;
        end else if (freeze_s) begin
            int_next_s = integrator_r;
        end else begin
            int_next_s = sat_add(integrator_r, s1_err_r);
        end
    end

    // S3 P+I sum. integrator_r here is the value this sample wrote in S2; a
    // following sample's update lands on the same edge this one is consumed.
    always_comb begin
        sum_next_s = sat_add(shift_sat(s2_err_r, s2_kp_r), shift_sat(integrator_r, s2_ki_r));
    end

    // S4 overall gain, optional negation and clip into the output range.
    always_comb begin
        gained_s = shift_sat(s3_sum_r, s3_kg_r);
        if (s3_kg_sign_r) begin
            gained_s = neg_sat(gained_s);
        end else begin
            gained_s = gained_s;
        end
        gained_w_s    = WIDE'(gained_s);
        action_next_s = OUT_MAX;
        clip_next_s   = 1'b0;
        dir_next_s    = 1'b0;
        if (gained_w_s > OUT_MAX_W) begin
            action_next_s = OUT_MAX;
            clip_next_s   = 1'b1;
            dir_next_s    = 1'b0;
        end else if (gained_w_s < OUT_MIN_W) begin
            action_next_s = OUT_MIN;
            clip_next_s   = 1'b1;
            dir_next_s    = 1'b1;
        end else begin
            action_next_s = gained_w_s[OUTPUT_WIDTH-1:0];
            clip_next_s   = 1'b0;
            dir_next_s    = 1'b0;
        end
    end

    // Map the internal action width onto the stream word width.
    generate
        if (AXIS_TDATA_WIDTH > OUTPUT_WIDTH) begin : g_widen
            assign mapped_s = {s4_action_r, {(AXIS_TDATA_WIDTH-OUTPUT_WIDTH){1'b0}}};
        end else if (AXIS_TDATA_WIDTH < OUTPUT_WIDTH) begin : g_narrow
            assign mapped_s = s4_action_r[OUTPUT_WIDTH-1 -: AXIS_TDATA_WIDTH];
        end else begin : g_equal
            assign mapped_s = s4_action_r;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // S1 register: capture error and the gains that travel with the sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_r   <= 1'b0;
            s1_err_r     <= {ACC_WIDTH{1'b0}};
            s1_kp_r      <= 8'sd0;
            s1_ki_r      <= 8'sd0;
            s1_kg_r      <= 8'sd0;
            s1_kg_sign_r <= 1'b0;
        end else begin
            s1_valid_r <= axis.s_axis_pv_tvalid;
            if (axis.s_axis_pv_tvalid) begin
                s1_err_r     <= err_s;
                s1_kp_r      <= kp;
                s1_ki_r      <= ki;
                s1_kg_r      <= kg;
                s1_kg_sign_r <= kg_sign;
            end
        end
    end

    // S2 register and integrator: the integrator only moves for a valid sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid_r   <= 1'b0;
            s2_err_r     <= {ACC_WIDTH{1'b0}};
            s2_kp_r      <= 8'sd0;
            s2_ki_r      <= 8'sd0;
            s2_kg_r      <= 8'sd0;
            s2_kg_sign_r <= 1'b0;
            integrator_r <= {ACC_WIDTH{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_err_r     <= s1_err_r;
                s2_kp_r      <= s1_kp_r;
                s2_ki_r      <= s1_ki_r;
                s2_kg_r      <= s1_kg_r;
                s2_kg_sign_r <= s1_kg_sign_r;
                integrator_r <= int_next_s;
            end
        end
    end

    // S3 register: P+I sum plus the output gain controls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s3_valid_r   <= 1'b0;
            s3_sum_r     <= {ACC_WIDTH{1'b0}};
            s3_kg_r      <= 8'sd0;
            s3_kg_sign_r <= 1'b0;
        end else begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                s3_sum_r     <= sum_next_s;
                s3_kg_r      <= s2_kg_r;
                s3_kg_sign_r <= s2_kg_sign_r;
            end
        end
    end

    // S4 register: clipped action and its clip status.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s4_valid_r  <= 1'b0;
            s4_action_r <= {OUTPUT_WIDTH{1'b0}};
            s4_clip_r   <= 1'b0;
            s4_dir_r    <= 1'b0;
        end else begin
            s4_valid_r <= s3_valid_r;
            if (s3_valid_r) begin
                s4_action_r <= action_next_s;
                s4_clip_r   <= clip_next_s;
                s4_dir_r    <= dir_next_s;
            end
        end
    end

    // Output register: data and saturation status hold between pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tdata_r    <= {AXIS_TDATA_WIDTH{1'b0}};
            tvalid_r   <= 1'b0;
            sat_flag_r <= 1'b0;
            sat_dir_r  <= 1'b0;
        end else begin
            tvalid_r <= s4_valid_r;
            if (s4_valid_r) begin
                tdata_r    <= mapped_s;
                sat_flag_r <= s4_clip_r;
                sat_dir_r  <= s4_dir_r;
            end
        end
    end

    assign axis.m_axis_action_tdata  = tdata_r;
    assign axis.m_axis_action_tvalid = tvalid_r;
    assign sat_flag                  = sat_flag_r;

endmodule
